// File: rtl/mcu_el2_pkg.sv
// Shared definitions for the EL2 decode GPR write-back control slice.
//   NB_TAGS_DEFAULT        : default number of non-blocking load tags
//   DIV_FIFO_DEPTH_DEFAULT : default depth of the divider result buffer
//   el2_gpr_wb_pkt_t       : one GPR write {valid, rd, data}
//   rd_hit()               : qualified register-index compare
package mcu_el2_pkg;

    localparam int NB_TAGS_DEFAULT        = 4;
    localparam int DIV_FIFO_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } el2_gpr_wb_pkt_t;

    function automatic logic rd_hit(input logic v, input logic [4:0] a, input logic [4:0] b);
        return v && (a == b);
    endfunction

endpackage

// File: rtl/mcu_el2_dec_gpr_wb_fifo.sv
// Divider result buffer with fall-through head: when empty, an incoming
// result is presented on head_* in the same cycle so it can drain without
// an extra cycle of latency.
//   clk, rst        : clock and asynchronous active-high reset
//   push, push_data : enqueue (caller guarantees !full)
//   pop             : dequeue the current head (only meaningful with head_valid)
//   head_valid/data : oldest entry, or the incoming one when empty
//   full            : no room for another entry
module mcu_el2_dec_gpr_wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        head_valid,
    output logic [31:0] head_data,
    output logic        full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   mem [DEPTH];
    logic          empty, wr_en, rd_en;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head_valid = !empty || push;
    assign head_data  = empty ? push_data : mem[rd_ptr];

    // A push that drains in the same cycle while empty never touches storage.
    assign wr_en = push && !(empty && pop);
    assign rd_en = pop && !empty;

    assign wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    assign count_nxt  = count + CW'(wr_en) - CW'(rd_en);

    mcu_rvdffe #(.WIDTH(PW)) u_wr_ptr (.clk(clk), .rst(rst), .en(wr_en), .din(wr_ptr_nxt), .dout(wr_ptr));
    mcu_rvdffe #(.WIDTH(PW)) u_rd_ptr (.clk(clk), .rst(rst), .en(rd_en), .din(rd_ptr_nxt), .dout(rd_ptr));
    mcu_rvdffe #(.WIDTH(CW)) u_count  (.clk(clk), .rst(rst), .en(wr_en || rd_en), .din(count_nxt), .dout(count));

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        mcu_rvdffe #(.WIDTH(32)) u_ent (
            .clk  (clk),
            .rst  (rst),
            .en   (wr_en && (wr_ptr == PW'(i))),
            .din  (push_data),
            .dout (mem[i])
        );
    end

endmodule

// File: rtl/mcu_rvdffe.sv
// Enabled flop bank with asynchronous active-high reset.
//   clk, rst : clock and reset
//   en       : load enable
//   din/dout : WIDTH-bit data in / registered data out
module mcu_rvdffe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/mcu_el2_dec_gpr_wb_ctl.sv
// GPR write-back control: routes ALU results (port 0), non-blocking load
// returns (port 1) and divider results (port 2) onto registered GPR write
// ports, tracks outstanding destinations for scoreboard queries, and kills
// older pending writes when a younger producer targets the same rd.
//   alu_wb_*          : ALU result, one per cycle
//   nb_alloc_*        : reserve rd under a load tag
//   nb_ret_*          : load data return by tag
//   div_alloc_*       : reserve rd for the divider
//   div_wb_*          : divider result valid/ready handshake
//   raddr0/1, rs*_busy: combinational scoreboard query
//   wen/waddr/wd 0..2 : registered GPR write ports
module mcu_el2_dec_gpr_wb_ctl
    import mcu_el2_pkg::*;
#(
    parameter  int NB_TAGS        = NB_TAGS_DEFAULT,
    parameter  int DIV_FIFO_DEPTH = DIV_FIFO_DEPTH_DEFAULT,
    localparam int TW             = (NB_TAGS > 1) ? $clog2(NB_TAGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_wb_valid,
    input  logic [4:0]    alu_wb_rd,
    input  logic [31:0]   alu_wb_data,
    input  logic          nb_alloc_valid,
    input  logic [TW-1:0] nb_alloc_tag,
    input  logic [4:0]    nb_alloc_rd,
    input  logic          nb_ret_valid,
    input  logic [TW-1:0] nb_ret_tag,
    input  logic [31:0]   nb_ret_data,
    input  logic          div_alloc_valid,
    input  logic [4:0]    div_alloc_rd,
    input  logic          div_wb_valid,
    input  logic [31:0]   div_wb_data,
    output logic          div_wb_ready,
    input  logic [4:0]    raddr0,
    input  logic [4:0]    raddr1,
    output logic          rs0_busy,
    output logic          rs1_busy,
    output logic          wen0,
    output logic [4:0]    waddr0,
    output logic [31:0]   wd0,
    output logic          wen1,
    output logic [4:0]    waddr1,
    output logic [31:0]   wd1,
    output logic          wen2,
    output logic [4:0]    waddr2,
    output logic [31:0]   wd2
);

    logic               alu_v, nba_v, diva_v;
    logic               ret_hit;
    logic [4:0]         ret_rd;
    logic [NB_TAGS-1:0] tag_valid, tag_kill;
    logic [4:0]         tag_rd [NB_TAGS];
    logic               div_busy, div_kill;
    logic [4:0]         div_rd;
    logic               fifo_push, fifo_pop, fifo_full, head_valid;
    logic [31:0]        head_data;
    logic               div_wen_req, div_block;
    el2_gpr_wb_pkt_t    wb0_nxt, wb1_nxt, wb2_nxt, wb0_q, wb1_q, wb2_q;

    // x0 is never written nor reserved.
    assign alu_v  = alu_wb_valid && (alu_wb_rd != 5'd0);
    assign nba_v  = nb_alloc_valid && (nb_alloc_rd != 5'd0);
    assign diva_v = div_alloc_valid && (div_alloc_rd != 5'd0);

    assign ret_hit = nb_ret_valid && tag_valid[nb_ret_tag] && !tag_kill[nb_ret_tag];
    assign ret_rd  = tag_rd[nb_ret_tag];

    // Allocation has priority over return on the same tag so a same-cycle
    // return completes (it already drives port 1) and the new owner lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_kill  <= '0;
            for (int i = 0; i < NB_TAGS; i++) tag_rd[i] <= '0;
        end else begin
            for (int i = 0; i < NB_TAGS; i++) begin
                if (nba_v && (nb_alloc_tag == TW'(i))) begin
                    tag_valid[i] <= 1'b1;
                    tag_kill[i]  <= 1'b0;
                    tag_rd[i]    <= nb_alloc_rd;
                end else if (nb_ret_valid && (nb_ret_tag == TW'(i))) begin
                    tag_valid[i] <= 1'b0;
                    tag_kill[i]  <= 1'b0;
                end else if (tag_valid[i] && !tag_kill[i] &&
                             (rd_hit(alu_v, alu_wb_rd, tag_rd[i]) ||
                              rd_hit(nba_v, nb_alloc_rd, tag_rd[i]) ||
                              rd_hit(diva_v, div_alloc_rd, tag_rd[i]))) begin
                    tag_kill[i] <= 1'b1;
                end
            end
        end
    end

    // div_rd/div_kill outlive div_busy so late results still drain against
    // the last reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_busy <= 1'b0;
            div_kill <= 1'b0;
            div_rd   <= '0;
        end else if (diva_v) begin
            div_busy <= 1'b1;
            div_kill <= 1'b0;
            div_rd   <= div_alloc_rd;
        end else begin
            if (fifo_pop) div_busy <= 1'b0;
            if (div_busy && !div_kill &&
                (rd_hit(alu_v, alu_wb_rd, div_rd) || rd_hit(nba_v, nb_alloc_rd, div_rd))) begin
                div_kill <= 1'b1;
            end
        end
    end

    assign div_wb_ready = !fifo_full;
    assign fifo_push    = div_wb_valid && div_wb_ready;

    // Port 2 loses any same-rd conflict with ports 0/1. Rather than lose the
    // divider result it stays in the buffer; that back-pressure is what
    // eventually deasserts div_wb_ready. Killed results drain silently.
    assign div_wen_req = head_valid && !div_kill && (div_rd != 5'd0);
    assign div_block   = div_wen_req &&
                         (rd_hit(alu_v, alu_wb_rd, div_rd) || rd_hit(ret_hit, ret_rd, div_rd));
    assign fifo_pop    = head_valid && !div_block;

    mcu_el2_dec_gpr_wb_fifo #(.DEPTH(DIV_FIFO_DEPTH)) u_div_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (div_wb_data),
        .pop        (fifo_pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .full       (fifo_full)
    );

    always_comb begin
        wb0_nxt = '0;
        wb1_nxt = '0;
        wb2_nxt = '0;
        if (alu_v) begin
            wb0_nxt.valid = 1'b1;
            wb0_nxt.rd    = alu_wb_rd;
            wb0_nxt.data  = alu_wb_data;
        end
        if (ret_hit && !rd_hit(alu_v, alu_wb_rd, ret_rd)) begin
            wb1_nxt.valid = 1'b1;
            wb1_nxt.rd    = ret_rd;
            wb1_nxt.data  = nb_ret_data;
        end
        if (div_wen_req && !div_block) begin
            wb2_nxt.valid = 1'b1;
            wb2_nxt.rd    = div_rd;
            wb2_nxt.data  = head_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb0_q <= '0;
            wb1_q <= '0;
            wb2_q <= '0;
        end else begin
            wb0_q <= wb0_nxt;
            wb1_q <= wb1_nxt;
            wb2_q <= wb2_nxt;
        end
    end

    assign wen0 = wb0_q.valid; assign waddr0 = wb0_q.rd; assign wd0 = wb0_q.data;
    assign wen1 = wb1_q.valid; assign waddr1 = wb1_q.rd; assign wd1 = wb1_q.data;
    assign wen2 = wb2_q.valid; assign waddr2 = wb2_q.rd; assign wd2 = wb2_q.data;

    always_comb begin
        rs0_busy = 1'b0;
        rs1_busy = 1'b0;
        for (int i = 0; i < NB_TAGS; i++) begin
            if (tag_valid[i] && !tag_kill[i]) begin
                rs0_busy = rs0_busy | rd_hit(raddr0 != 5'd0, raddr0, tag_rd[i]);
                rs1_busy = rs1_busy | rd_hit(raddr1 != 5'd0, raddr1, tag_rd[i]);
            end
        end
        if (div_busy && !div_kill) begin
            rs0_busy = rs0_busy | rd_hit(raddr0 != 5'd0, raddr0, div_rd);
            rs1_busy = rs1_busy | rd_hit(raddr1 != 5'd0, raddr1, div_rd);
        end
    end

endmodule

// File: tb/tb_mcu_el2_dec_gpr_wb_ctl.sv
module tb_mcu_el2_dec_gpr_wb_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        nb_alloc_valid;
    logic [1:0]  nb_alloc_tag;
    logic [4:0]  nb_alloc_rd;
    logic        nb_ret_valid;
    logic [1:0]  nb_ret_tag;
    logic [31:0] nb_ret_data;
    logic        div_alloc_valid;
    logic [4:0]  div_alloc_rd;
    logic        div_wb_valid;
    logic [31:0] div_wb_data;
    logic        div_wb_ready;
    logic [4:0]  raddr0, raddr1;
    logic        rs0_busy, rs1_busy;
    logic        wen0, wen1, wen2;
    logic [4:0]  waddr0, waddr1, waddr2;
    logic [31:0] wd0, wd1, wd2;

    int tests = 0;
    int fails = 0;

    // expected writes per port: {rd, data}
    logic [36:0] q0[$];
    logic [36:0] q1[$];
    logic [36:0] q2[$];

    always #5 clk = ~clk;

    mcu_el2_dec_gpr_wb_ctl dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .nb_alloc_valid(nb_alloc_valid), .nb_alloc_tag(nb_alloc_tag), .nb_alloc_rd(nb_alloc_rd),
        .nb_ret_valid(nb_ret_valid), .nb_ret_tag(nb_ret_tag), .nb_ret_data(nb_ret_data),
        .div_alloc_valid(div_alloc_valid), .div_alloc_rd(div_alloc_rd),
        .div_wb_valid(div_wb_valid), .div_wb_data(div_wb_data), .div_wb_ready(div_wb_ready),
        .raddr0(raddr0), .raddr1(raddr1), .rs0_busy(rs0_busy), .rs1_busy(rs1_busy),
        .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
        .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
        .wen2(wen2), .waddr2(waddr2), .wd2(wd2)
    );

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        nb_alloc_valid = 0; nb_alloc_tag = 0; nb_alloc_rd = 0;
        nb_ret_valid = 0; nb_ret_tag = 0; nb_ret_data = 0;
        div_alloc_valid = 0; div_alloc_rd = 0;
        div_wb_valid = 0; div_wb_data = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_wen"}, {wen0, wen1, wen2}, 0);
        check({tag, "_port0"}, {waddr0, wd0}, 0);
        check({tag, "_port1"}, {waddr1, wd1}, 0);
        check({tag, "_port2"}, {waddr2, wd2}, 0);
        check({tag, "_ready"}, div_wb_ready, 1);
    endtask

    // Scoreboard monitor: every write the DUT presents must match the oldest
    // expected write for that port.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL port0_unexpected: got rd=%0d data=%h expected no write", waddr0, wd0);
                end else check("port0_write", {waddr0, wd0}, q0.pop_front());
            end
            if (wen1) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL port1_unexpected: got rd=%0d data=%h expected no write", waddr1, wd1);
                end else check("port1_write", {waddr1, wd1}, q1.pop_front());
            end
            if (wen2) begin
                if (q2.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL port2_unexpected: got rd=%0d data=%h expected no write", waddr2, wd2);
                end else check("port2_write", {waddr2, wd2}, q2.pop_front());
            end
        end
    end

    initial begin
        rst = 1;
        idle_inputs();
        raddr0 = 0; raddr1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 0;
        tick();

        // ALU write, rd=5
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF;
        q0.push_back({5'd5, 32'hDEADBEEF});
        tick();
        idle_inputs();
        check("alu_wen0_latency", wen0, 1);

        // ALU write to x0 is suppressed
        alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h11111111;
        tick();
        idle_inputs();
        check("alu_x0_no_wen", wen0, 0);

        // load tag 2 -> rd 7
        nb_alloc_valid = 1; nb_alloc_tag = 2; nb_alloc_rd = 7;
        tick();
        idle_inputs();
        raddr0 = 7; raddr1 = 7;
        #1;
        check("ld_busy_rs0", rs0_busy, 1);
        check("ld_busy_rs1", rs1_busy, 1);
        nb_ret_valid = 1; nb_ret_tag = 2; nb_ret_data = 32'h1234;
        q1.push_back({5'd7, 32'h1234});
        tick();
        idle_inputs();
        check("ld_ret_wen1", wen1, 1);
        check("ld_busy_cleared", rs0_busy, 0);

        // load tag 1 -> rd 9, killed by younger ALU write
        nb_alloc_valid = 1; nb_alloc_tag = 1; nb_alloc_rd = 9;
        tick();
        idle_inputs();
        alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h99;
        q0.push_back({5'd9, 32'h99});
        tick();
        idle_inputs();
        raddr0 = 9;
        #1;
        check("kill_busy_rs0", rs0_busy, 0);
        nb_ret_valid = 1; nb_ret_tag = 1; nb_ret_data = 32'h5555;
        tick();
        idle_inputs();
        check("kill_ret_no_wen1", wen1, 0);

        // load alloc to x0 leaves no entry; its return writes nothing
        nb_alloc_valid = 1; nb_alloc_tag = 3; nb_alloc_rd = 0;
        tick();
        idle_inputs();
        nb_ret_valid = 1; nb_ret_tag = 3; nb_ret_data = 32'h7777;
        tick();
        idle_inputs();
        check("x0_ret_no_wen1", wen1, 0);

        // divider rd=3: first result drains, then ALU collisions back up the buffer
        div_alloc_valid = 1; div_alloc_rd = 3;
        tick();
        idle_inputs();
        raddr1 = 3;
        #1;
        check("div_busy_rs1", rs1_busy, 1);
        div_wb_valid = 1; div_wb_data = 32'h100;
        q2.push_back({5'd3, 32'h100});
        tick();
        idle_inputs();
        check("div_first_wen2", wen2, 1);
        check("div_busy_cleared", rs1_busy, 0);

        alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'hA1;
        div_wb_valid = 1; div_wb_data = 32'h101;
        q0.push_back({5'd3, 32'hA1});
        q2.push_back({5'd3, 32'h101});
        check("fifo_ready_0", div_wb_ready, 1);
        tick();
        check("div_stalled_no_wen2", wen2, 0);
        alu_wb_data = 32'hA2; div_wb_data = 32'h102;
        q0.push_back({5'd3, 32'hA2});
        q2.push_back({5'd3, 32'h102});
        check("fifo_ready_1", div_wb_ready, 1);
        tick();
        alu_wb_data = 32'hA3; div_wb_data = 32'h103;
        q0.push_back({5'd3, 32'hA3});
        check("fifo_full_ready", div_wb_ready, 0);
        tick();
        alu_wb_valid = 0;
        check("fifo_still_full", div_wb_ready, 0);
        tick();
        check("fifo_ready_after_drain", div_wb_ready, 1);
        q2.push_back({5'd3, 32'h103});
        tick();
        idle_inputs();
        repeat (2) tick();

        // load return and divider drain to rd=4 in the same cycle
        nb_alloc_valid = 1; nb_alloc_tag = 0; nb_alloc_rd = 4;
        div_alloc_valid = 1; div_alloc_rd = 4;
        tick();
        idle_inputs();
        raddr0 = 4;
        #1;
        check("dual_busy_rs0", rs0_busy, 1);
        nb_ret_valid = 1; nb_ret_tag = 0; nb_ret_data = 32'h4444;
        div_wb_valid = 1; div_wb_data = 32'h4000;
        q1.push_back({5'd4, 32'h4444});
        q2.push_back({5'd4, 32'h4000});
        tick();
        idle_inputs();
        check("conflict_wen1_only", {wen0, wen1, wen2}, 3'b010);
        tick();
        check("conflict_div_deferred", wen2, 1);

        // reset with tag 0 pending
        nb_alloc_valid = 1; nb_alloc_tag = 0; nb_alloc_rd = 10;
        tick();
        idle_inputs();
        alu_wb_valid = 1; alu_wb_rd = 12; alu_wb_data = 32'hC0C0;
        q0.push_back({5'd12, 32'hC0C0});
        tick();
        idle_inputs();
        @(negedge clk);
        #1;
        rst = 1;
        raddr0 = 10;
        #1;
        check_cleared("rst_pulse");
        check("rst_busy_rs0", rs0_busy, 0);
        tick();
        rst = 0;
        nb_ret_valid = 1; nb_ret_tag = 0; nb_ret_data = 32'hBAD;
        tick();
        idle_inputs();
        check("late_ret_no_wen1", wen1, 0);
        repeat (3) tick();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
